accum_bank: RTL and testbench
=============================

Name: accum_bank

Overview:
Multi-column, pipelined read-modify-write accumulator bank for the systolic array output path.
- NUM_COLS independent columns share one row address.
- Write side adds, or overwrites, a vector of partial sums into a row; read side drains rows, optionally clearing them.
- Adds three things to the single-column accumulator: valid/ready handshakes, same-row forwarding, and a sweeping clear FSM.

Parameters:
NUM_COLS, 16, number of accumulator columns
ACCUM_ROW, 256, rows per column (power of two, >=4)
IN_WIDTH, 24, signed partial-sum input width per column
DATA_WIDTH, 32, signed accumulator width per column (>= IN_WIDTH)
ADDR_WIDTH, $clog2(ACCUM_ROW), localparam row address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clear_req  in  1  pulse: start zero-sweep of all rows
busy  out  1  high while clear sweep runs
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid&&wr_ready
wr_addr  in  ADDR_WIDTH  target row
wr_mode  in  1  0=accumulate, 1=overwrite
wr_mask  in  NUM_COLS  per-column enable; masked columns unchanged
wr_data  in  NUM_COLS*IN_WIDTH  packed signed partial sums, column 0 in LSBs
rd_valid  in  1  readout request
rd_ready  out  1  readout accepted when rd_valid&&rd_ready
rd_addr  in  ADDR_WIDTH  row to read
rd_clear  in  1  zero row after read
rd_data_valid  out  1  registered read data valid
rd_data  out  NUM_COLS*DATA_WIDTH  packed row contents

Behaviour:
- Interface decision: one clock, clk. Reset rst is synchronous and active-high.
- Reset: FSM enters CLEAR at row 0. All pipeline valids are 0, busy=1, wr_ready=0, rd_ready=0, rd_data_valid=0, rd_data=0.
- FSM states: CLEAR and RUN.
  - CLEAR writes zero to one row per cycle, ascending; busy=1; both readies 0.
  - After row ACCUM_ROW-1 is written, the next cycle is RUN. A full sweep takes exactly ACCUM_ROW cycles.
  - RUN: clear_req moves to CLEAR at row 0 once the write pipeline is empty. While draining, both readies are held 0.
  - clear_req during CLEAR is ignored. rst mid-operation restarts CLEAR at row 0 and drops in-flight writes and reads.
- Memory: 1 read port, 1 write port, registered read (SRAM-style).
- Write pipeline:
  - S1 (accept cycle T): memory read of wr_addr is issued.
  - S2 (T+1): sum or overwrite is computed and written; the row is visible to a read accepted at T+2 or later.
  - Sustained throughput is 1 write per cycle.
- Arithmetic:
  - Input is sign-extended IN_WIDTH to DATA_WIDTH.
  - Accumulate = old + ext(in), wrapping modulo 2^DATA_WIDTH.
  - Overwrite = ext(in).
- Forwarding: if the S2 address equals the S1 address, S2's computed row replaces the memory read data for that op. Back-to-back accumulates to one row therefore sum exactly; no stall.
- Arbitration in RUN:
  - A read owns the memory read port, so wr_ready = !rd_valid.
  - rd_ready = 0 while S1 or S2 holds a valid write to rd_addr (hazard). Otherwise rd_ready = 1.
  - rd_ready = 0 when rd_clear=1 and S2 is valid (write-port conflict).
- Read timing: accepted at T gives rd_data_valid=1 at T+1 with the row contents; rd_data holds its value otherwise.
- Read-and-clear: the row is zeroed at T+1 via the write port; the next read returns 0.
- wr_mask=0 with wr_valid is a legal no-op that still occupies the pipeline.
- Address wrap does not occur: addresses are ADDR_WIDTH wide and ACCUM_ROW is a power of two.

Optional Feature:
Macro ACCUM_BANK_SATURATE_EN.
- Defined: the accumulate result saturates to the signed range, 2^(DATA_WIDTH-1)-1 and -2^(DATA_WIDTH-1). Adds sat_flag out 1: a sticky OR of any saturation event, cleared by rst or clear_req.
- Undefined: wrap-around addition and no sat_flag port.

Decomposition:
- Package accum_pkg holds:
  - the accum_mode_e enum (ACC, OVR)
  - the accum_state_e enum (CLEAR, RUN)
  - the sign-extend function and the saturating-add function
- Sub-module accum_lane: one column's combinational sign-extend, add or overwrite, and optional saturate. It is instantiated NUM_COLS times in S2.

Test Plan:
- Reset then idle: busy=1 for exactly 256 cycles → busy=0; read row 255 → rd_data all zero.
- Accumulate back-to-back: row 5, col 0, inputs +3,+4,-10 on consecutive cycles → read returns -3.
- Overwrite and mask: overwrite row 7 with 100 on all columns, then accumulate 1 with mask=0x0001 → col0=101, col1..15=100.
- Read hazard and read-and-clear:
  - A write to row 9 at T plus a read of row 9 at T+1 → rd_ready=0 at T+1; data returned includes the write.
  - A read with rd_clear=1 → the second read returns 0.
- Arbitration: rd_valid and wr_valid held together for 4 cycles → wr_ready=0 throughout; no write lost after rd_valid drops.
- Overflow (DATA_WIDTH=8, IN_WIDTH=8): accumulate 127 then +1 → -128 without the macro; 127 with sat_flag=1 when defined.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and arithmetic helpers for the accumulator bank.
// Helpers work on a 64-bit carrier and take the live width as an argument.
package accum_pkg;

  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] wide_t;

  typedef enum logic {
    ACC = 1'b0,
    OVR = 1'b1
  } accum_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } accum_state_e;

  typedef struct packed {
    logic  sat;
    wide_t value;
  } sat_result_t;

  // Sign-extend the low w bits of v to the full carrier width.
  function automatic wide_t sign_ext(input wide_t v, input int w);
    int sh;
    sh = MAX_W - w;
    return wide_t'($signed(v << sh) >>> sh);
  endfunction

  // a and b are already sign-extended w-bit values; clamp the sum to w-bit signed range.
  function automatic sat_result_t sat_add(input wide_t a, input wide_t b, input int w);
    sat_result_t r;
    wide_t       sum;
    wide_t       max_v;
    wide_t       min_v;
    sum   = a + b;
    max_v = (wide_t'(1) << (w - 1)) - wide_t'(1);
    min_v = ~max_v;
    r.sat   = 1'b0;
    r.value = sum;
    if ($signed(sum) > $signed(max_v)) begin
      r.value = max_v;
      r.sat   = 1'b1;
    end else if ($signed(sum) < $signed(min_v)) begin
      r.value = min_v;
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_lane.sv
// One column of the accumulate stage: sign-extend, add or overwrite, optional clamp.
// Saturation and the sat output exist only when ACCUM_BANK_SATURATE_EN is defined.
module accum_lane #(
  parameter int IN_WIDTH   = 24,
  parameter int DATA_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0]   part,
  input  logic [DATA_WIDTH-1:0] old,
  input  logic                  mode,
  input  logic                  en,
`ifdef ACCUM_BANK_SATURATE_EN
  output logic                  sat,
`endif
  output logic [DATA_WIDTH-1:0] result
);
  import accum_pkg::*;

  wide_t                 ext;
  logic [DATA_WIDTH-1:0] ext_n;
  logic [DATA_WIDTH-1:0] sum;
`ifdef ACCUM_BANK_SATURATE_EN
  sat_result_t           add_res;
`endif

  always_comb begin
    ext   = sign_ext(wide_t'(part), IN_WIDTH);
    ext_n = DATA_WIDTH'(ext);
`ifdef ACCUM_BANK_SATURATE_EN
    add_res = sat_add(sign_ext(wide_t'(old), DATA_WIDTH), ext, DATA_WIDTH);
    sum     = DATA_WIDTH'(add_res.value);
    sat     = en && (accum_mode_e'(mode) == ACC) && add_res.sat;
`else
    sum     = old + ext_n;
`endif
    // Disabled columns pass the old row through so the whole row can be rewritten.
    result = old;
    if (en) begin
      result = (accum_mode_e'(mode) == OVR) ? ext_n : sum;
    end
  end

endmodule

// File: rtl/accum_bank.sv
// Multi-column pipelined read-modify-write accumulator bank with clear sweep.
// Define ACCUM_BANK_SATURATE_EN for saturating accumulate and the sat_flag output.
module accum_bank #(
  parameter int NUM_COLS   = 16,
  parameter int ACCUM_ROW  = 256,
  parameter int IN_WIDTH   = 24,
  parameter int DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(ACCUM_ROW)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear_req,
  output logic                           busy,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic                           wr_mode,
  input  logic [NUM_COLS-1:0]            wr_mask,
  input  logic [NUM_COLS*IN_WIDTH-1:0]   wr_data,
  input  logic                           rd_valid,
  output logic                           rd_ready,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  input  logic                           rd_clear,
  output logic                           rd_data_valid,
`ifdef ACCUM_BANK_SATURATE_EN
  output logic                           sat_flag,
`endif
  output logic [NUM_COLS*DATA_WIDTH-1:0] rd_data
);
  import accum_pkg::*;

  localparam int ROW_W = NUM_COLS * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ACCUM_ROW - 1);

  accum_state_e                 state_reg;
  logic [ADDR_WIDTH-1:0]        sweep_reg;
  logic                         busy_reg;
  logic                         clear_pend_reg;

  logic                         s2_valid_reg;
  logic [ADDR_WIDTH-1:0]        s2_addr_reg;
  accum_mode_e                  s2_mode_reg;
  logic [NUM_COLS-1:0]          s2_mask_reg;
  logic [NUM_COLS*IN_WIDTH-1:0] s2_data_reg;
  logic                         fwd_reg;
  logic [ROW_W-1:0]             fwd_row_reg;

  logic [ROW_W-1:0]             mem [ACCUM_ROW];
  logic [ROW_W-1:0]             mem_rd_data_reg;
  logic [ADDR_WIDTH-1:0]        mem_raddr;
  logic                         mem_we;
  logic [ADDR_WIDTH-1:0]        mem_waddr;
  logic [ROW_W-1:0]             mem_wdata;

  logic                         rd_data_valid_reg;
  logic [ROW_W-1:0]             rd_hold_reg;
  logic [ROW_W-1:0]             old_row;
  logic [ROW_W-1:0]             new_row;
  logic                         run_open;
  logic                         wr_fire;
  logic                         rd_fire;
`ifdef ACCUM_BANK_SATURATE_EN
  logic [NUM_COLS-1:0]          lane_sat;
  logic                         sat_flag_reg;
`endif

  // A pending clear closes both handshakes so the write pipeline can drain.
  assign run_open = (state_reg == RUN) && !clear_req && !clear_pend_reg;
  assign wr_ready = run_open && !rd_valid;
  // Only S2 can hold an unwritten row when a read is presented, since a read blocks S1 acceptance.
  assign rd_ready = run_open
                    && !(s2_valid_reg && (s2_addr_reg == rd_addr))
                    && !(rd_clear && s2_valid_reg);
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_fire  = rd_valid && rd_ready;
  assign busy     = busy_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= CLEAR;
      sweep_reg      <= '0;
      busy_reg       <= 1'b1;
      clear_pend_reg <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          sweep_reg <= sweep_reg + ADDR_WIDTH'(1);
          if (sweep_reg == LAST_ROW) begin
            state_reg <= RUN;
            busy_reg  <= 1'b0;
          end
        end
        RUN: begin
          if (clear_req || clear_pend_reg) begin
            if (s2_valid_reg) begin
              clear_pend_reg <= 1'b1;
            end else begin
              clear_pend_reg <= 1'b0;
              state_reg      <= CLEAR;
              sweep_reg      <= '0;
              busy_reg       <= 1'b1;
            end
          end
        end
        default: state_reg <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg      <= 1'b0;
      rd_data_valid_reg <= 1'b0;
      rd_hold_reg       <= '0;
    end else begin
      s2_valid_reg      <= wr_fire;
      rd_data_valid_reg <= rd_fire;
      rd_hold_reg       <= rd_data;
    end
  end

  // Forwarding: the op entering S2 next cycle reads the row S2 is writing now.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      s2_addr_reg <= wr_addr;
      s2_mode_reg <= accum_mode_e'(wr_mode);
      s2_mask_reg <= wr_mask;
      s2_data_reg <= wr_data;
    end
    fwd_reg     <= s2_valid_reg && (s2_addr_reg == wr_addr);
    fwd_row_reg <= new_row;
  end

  assign mem_raddr = rd_fire ? rd_addr : wr_addr;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = s2_addr_reg;
    mem_wdata = new_row;
    if (state_reg == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_reg;
      mem_wdata = '0;
    end else if (s2_valid_reg) begin
      mem_we = 1'b1;
    end else if (rd_fire && rd_clear) begin
      mem_we    = 1'b1;
      mem_waddr = rd_addr;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    mem_rd_data_reg <= mem[mem_raddr];
  end

  assign old_row = fwd_reg ? fwd_row_reg : mem_rd_data_reg;
  assign rd_data = rd_data_valid_reg ? mem_rd_data_reg : rd_hold_reg;
  assign rd_data_valid = rd_data_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_lane
      accum_lane #(
        .IN_WIDTH  (IN_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
      ) u_lane (
        .part  (s2_data_reg[gi*IN_WIDTH +: IN_WIDTH]),
        .old   (old_row[gi*DATA_WIDTH +: DATA_WIDTH]),
        .mode  (s2_mode_reg),
        .en    (s2_mask_reg[gi]),
`ifdef ACCUM_BANK_SATURATE_EN
        .sat   (lane_sat[gi]),
`endif
        .result(new_row[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

`ifdef ACCUM_BANK_SATURATE_EN
  always_ff @(posedge clk) begin
    if (rst || clear_req) begin
      sat_flag_reg <= 1'b0;
    end else if (s2_valid_reg && (|lane_sat)) begin
      sat_flag_reg <= 1'b1;
    end
  end
  assign sat_flag = sat_flag_reg;
`endif

endmodule

// File: tb/tb_accum_bank.sv
// Directed bench for accum_bank: a full-size bank plus a narrow 8-bit bank for overflow.
// Build with ACCUM_BANK_SATURATE_EN to exercise the saturating variant.
module tb_accum_bank;
  localparam int NC  = 16;
  localparam int IW  = 24;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int SNC = 2;
  localparam int SW  = 8;
  localparam int SAW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, clear_req, busy;
  logic              wr_valid, wr_ready, wr_mode;
  logic [AW-1:0]     wr_addr;
  logic [NC-1:0]     wr_mask;
  logic [NC*IW-1:0]  wr_data;
  logic              rd_valid, rd_ready, rd_clear, rd_data_valid;
  logic [AW-1:0]     rd_addr;
  logic [NC*DW-1:0]  rd_data;

  logic              s_clear_req, s_busy;
  logic              s_wr_valid, s_wr_ready, s_wr_mode;
  logic [SAW-1:0]    s_wr_addr;
  logic [SNC-1:0]    s_wr_mask;
  logic [SNC*SW-1:0] s_wr_data;
  logic              s_rd_valid, s_rd_ready, s_rd_clear, s_rd_data_valid;
  logic [SAW-1:0]    s_rd_addr;
  logic [SNC*SW-1:0] s_rd_data;
`ifdef ACCUM_BANK_SATURATE_EN
  logic              sat_flag, s_sat_flag;
`endif

  accum_bank #(.NUM_COLS(NC), .ACCUM_ROW(256), .IN_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_mode(wr_mode),
    .wr_mask(wr_mask), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_clear(rd_clear),
    .rd_data_valid(rd_data_valid),
`ifdef ACCUM_BANK_SATURATE_EN
    .sat_flag(sat_flag),
`endif
    .rd_data(rd_data)
  );

  accum_bank #(.NUM_COLS(SNC), .ACCUM_ROW(4), .IN_WIDTH(SW), .DATA_WIDTH(SW)) dut_small (
    .clk(clk), .rst(rst), .clear_req(s_clear_req), .busy(s_busy),
    .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_addr(s_wr_addr), .wr_mode(s_wr_mode),
    .wr_mask(s_wr_mask), .wr_data(s_wr_data),
    .rd_valid(s_rd_valid), .rd_ready(s_rd_ready), .rd_addr(s_rd_addr), .rd_clear(s_rd_clear),
    .rd_data_valid(s_rd_data_valid),
`ifdef ACCUM_BANK_SATURATE_EN
    .sat_flag(s_sat_flag),
`endif
    .rd_data(s_rd_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NC*IW-1:0] fill_in(input int v);
    logic [NC*IW-1:0] r;
    for (int c = 0; c < NC; c++) r[c*IW +: IW] = IW'(v);
    return r;
  endfunction

  function automatic logic [NC*DW-1:0] fill_row(input int v);
    logic [NC*DW-1:0] r;
    for (int c = 0; c < NC; c++) r[c*DW +: DW] = DW'(v);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a write and leave wr_valid high so consecutive calls stream back-to-back.
  task automatic wr_issue(input int a, input logic m, input logic [NC-1:0] k, input logic [NC*IW-1:0] d);
    int n;
    n = 0;
    wr_valid = 1'b1; wr_addr = AW'(a); wr_mode = m; wr_mask = k; wr_data = d;
    #1;
    while (!wr_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_eq("wr_ready", wr_ready, 1);
    $display("wr row %0d mode %0d mask %04h", a, m, k);
    tick;
  endtask

  task automatic rd_row(input int a, input logic clr, output logic [NC*DW-1:0] d);
    int n;
    n = 0;
    rd_valid = 1'b1; rd_addr = AW'(a); rd_clear = clr;
    #1;
    while (!rd_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_eq("rd_ready", rd_ready, 1);
    tick;
    rd_valid = 1'b0; rd_clear = 1'b0;
    check_eq("rd_data_valid", rd_data_valid, 1);
    d = rd_data;
    $display("rd row %0d clear %0d -> %0h", a, clr, d);
  endtask

  task automatic sweep_len(output int n);
    n = 0;
    while (busy && n < 1000) begin
      tick;
      n++;
    end
  endtask

  logic [NC*DW-1:0] d, exp_row;
  int n;

  initial begin
    rst = 1'b1; clear_req = 1'b0;
    wr_valid = 1'b0; wr_mode = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0; rd_clear = 1'b0;
    s_clear_req = 1'b0; s_wr_valid = 1'b0; s_wr_mode = 1'b0; s_wr_addr = '0;
    s_wr_mask = '0; s_wr_data = '0; s_rd_valid = 1'b0; s_rd_addr = '0; s_rd_clear = 1'b0;
    repeat (3) tick;
    check_eq("rst_busy", busy, 1);
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_rd_ready", rd_ready, 0);
    check_eq("rst_rd_data_valid", rd_data_valid, 0);
    check_eq("rst_rd_data", rd_data, 0);

    rst = 1'b0;
    sweep_len(n);
    check_eq("init_sweep_cycles", n, 256);
    check_eq("run_wr_ready", wr_ready, 1);
    check_eq("run_rd_ready", rd_ready, 1);
    rd_row(255, 1'b0, d);
    check_eq("row255_zero", d, 0);

    // Back-to-back accumulates into one row exercise forwarding.
    wr_issue(5, 1'b0, 16'h0001, fill_in(3));
    wr_issue(5, 1'b0, 16'h0001, fill_in(4));
    wr_issue(5, 1'b0, 16'h0001, fill_in(-10));
    wr_valid = 1'b0;
    rd_row(5, 1'b0, d);
    exp_row = '0;
    exp_row[31:0] = 32'hFFFF_FFFD;
    check_eq("acc_b2b", d, exp_row);

    wr_issue(7, 1'b1, 16'hFFFF, fill_in(100));
    wr_issue(7, 1'b0, 16'h0001, fill_in(1));
    wr_valid = 1'b0;
    rd_row(7, 1'b0, d);
    exp_row = fill_row(100);
    exp_row[31:0] = 32'd101;
    check_eq("ovr_mask", d, exp_row);

    wr_issue(9, 1'b0, 16'hFFFF, fill_in(50));
    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 8'd9; rd_clear = 1'b0;
    #1;
    check_eq("rd_hazard", rd_ready, 0);
    tick;
    rd_row(9, 1'b0, d);
    check_eq("hazard_data", d, fill_row(50));
    rd_row(9, 1'b1, d);
    check_eq("rdclr_first", d, fill_row(50));
    rd_row(9, 1'b0, d);
    check_eq("rdclr_second", d, 0);

    // Read and write requested together: the read wins every cycle.
    rd_valid = 1'b1; rd_addr = 8'd7; rd_clear = 1'b0;
    wr_valid = 1'b1; wr_addr = 8'd12; wr_mode = 1'b0; wr_mask = 16'hFFFF; wr_data = fill_in(5);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("arb_wr_ready_%0d", i), wr_ready, 0);
      tick;
    end
    check_eq("arb_rd_data", rd_data, exp_row);
    rd_valid = 1'b0;
    wr_issue(12, 1'b0, 16'hFFFF, fill_in(5));
    wr_valid = 1'b0;
    rd_row(12, 1'b0, d);
    check_eq("arb_wr_once", d, fill_row(5));

    wr_issue(12, 1'b0, 16'hFFFF, fill_in(1));
    wr_valid = 1'b0;
    repeat (3) tick;
    check_eq("hold_rd_data_valid", rd_data_valid, 0);
    check_eq("hold_rd_data", rd_data, fill_row(5));

    // clear_req while S2 is busy: one drain cycle, then a full sweep.
    wr_issue(3, 1'b0, 16'hFFFF, fill_in(7));
    wr_valid = 1'b0;
    clear_req = 1'b1;
    #1;
    check_eq("clr_req_wr_ready", wr_ready, 0);
    tick;
    clear_req = 1'b0;
    #1;
    check_eq("drain_busy", busy, 0);
    check_eq("drain_wr_ready", wr_ready, 0);
    check_eq("drain_rd_ready", rd_ready, 0);
    tick;
    check_eq("clr_busy", busy, 1);
    sweep_len(n);
    check_eq("clr_sweep_cycles", n, 256);
    rd_row(3, 1'b0, d);
    check_eq("clr_row3", d, 0);
    rd_row(7, 1'b0, d);
    check_eq("clr_row7", d, 0);

    // Narrow bank: col0 127 then +1, col1 -128 then -1.
    check_eq("s_busy", s_busy, 0);
`ifdef ACCUM_BANK_SATURATE_EN
    check_eq("s_sat_init", s_sat_flag, 0);
`endif
    s_wr_valid = 1'b1; s_wr_addr = 2'd1; s_wr_mode = 1'b0; s_wr_mask = 2'b11;
    s_wr_data = 16'h807F;
    #1;
    check_eq("s_wr_ready_a", s_wr_ready, 1);
    tick;
    s_wr_data = 16'hFF01;
    #1;
    check_eq("s_wr_ready_b", s_wr_ready, 1);
    tick;
    s_wr_valid = 1'b0;
    tick;
    s_rd_valid = 1'b1; s_rd_addr = 2'd1;
    #1;
    check_eq("s_rd_ready", s_rd_ready, 1);
    tick;
    s_rd_valid = 1'b0;
    check_eq("s_rd_data_valid", s_rd_data_valid, 1);
    $display("rd small row 1 -> %04h", s_rd_data);
`ifdef ACCUM_BANK_SATURATE_EN
    check_eq("s_overflow_sat", s_rd_data, 16'h807F);
    check_eq("s_sat_set", s_sat_flag, 1);
    s_clear_req = 1'b1;
    tick;
    s_clear_req = 1'b0;
    check_eq("s_sat_clr", s_sat_flag, 0);
`else
    check_eq("s_overflow_wrap", s_rd_data, 16'h7F80);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
